// File: rtl/quadrature_counter_pkg.sv
// Shared types for the quadrature counter: step classification, widths and
// the Gray-position helper used by the decoder.
package quadrature_counter_pkg;

  localparam int COUNT_WIDTH_DEFAULT = 32;
  localparam int PERIOD_WIDTH        = 16;

  // Encodings equal the modulo-4 position difference, so classify() is a cast.
  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_ILLEGAL = 2'd2,
    STEP_REV     = 2'd3
  } step_e;

  // Position of an AB pair (bit0 = A, bit1 = B) along 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic step_e classify(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    diff = gray_pos(cur) - gray_pos(prev);
    return step_e'(diff);
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One quadrature pin: two-flop synchroniser followed by a stability filter
// that accepts a change only after FILTER_LEN consecutive differing samples.
module quad_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt,
  output logic ready
);

  localparam int WARM_W = $clog2(FILTER_LEN + 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(FILTER_LEN + 1);

  logic              s1;
  logic              s2;
  logic [WARM_W-1:0] warm;

  // After reset release, wait until s2 holds a real pin sample before the
  // filtered value is trusted; ready marks the one-shot reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      warm  <= '0;
      ready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1 <= pin;
      s2 <= s1;
      if (!ready) begin
        if (warm == WARM_LAST) ready <= 1'b1;
        else                   warm  <= warm + 1'b1;
      end
    end
  end

  if (FILTER_LEN == 0) begin : g_bypass
    assign filt = s2;
  end else begin : g_filter
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        filt_q <= 1'b0;
      end else if (!ready) begin
        cnt <= '0;
        if (warm == WARM_LAST) filt_q <= s2;
      end else if (s2 == filt_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt_q <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign filt = filt_q;
  end

endmodule

// File: rtl/quadrature_counter.sv
// Per-wheel 4x quadrature decoder with signed position count and snapshot.
// Optional QUAD_VELOCITY_EN adds PERIOD / PERIOD_LATCHED step-interval outputs.
module quadrature_counter
  import quadrature_counter_pkg::*;
#(
  parameter int FILTER_LEN  = 3,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [1:0]              SENSOR,
  input  logic                    SNAPSHOT,
  input  logic                    CLEAR,
  output logic [COUNT_WIDTH-1:0]  COUNT,
  output logic [COUNT_WIDTH-1:0]  COUNT_LATCHED,
  output logic                    DIR,
  output logic                    ERROR
`ifdef QUAD_VELOCITY_EN
  ,
  output logic [PERIOD_WIDTH-1:0] PERIOD,
  output logic [PERIOD_WIDTH-1:0] PERIOD_LATCHED
`endif
);

  logic filt_a, filt_b;
  logic ready_a, ready_b;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_a (
    .clk   (CLK),
    .rst_n (RESET_N),
    .pin   (SENSOR[0]),
    .filt  (filt_a),
    .ready (ready_a)
  );

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_b (
    .clk   (CLK),
    .rst_n (RESET_N),
    .pin   (SENSOR[1]),
    .filt  (filt_b),
    .ready (ready_b)
  );

  logic [1:0] cur_ab;
  logic [1:0] prev_ab;
  logic       armed;

  // Until armed, prev tracks cur so the post-reset reload never counts a step.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_ab  <= 2'b00;
      prev_ab <= 2'b00;
      armed   <= 1'b0;
    end else begin
      armed   <= ready_a & ready_b;
      cur_ab  <= {filt_b, filt_a};
      prev_ab <= armed ? cur_ab : {filt_b, filt_a};
    end
  end

  step_e                  step;
  logic                   moved;
  logic [COUNT_WIDTH-1:0] delta;
  logic [COUNT_WIDTH-1:0] count_next;

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    step  = armed ? classify(prev_ab, cur_ab) : STEP_NONE;
    delta = '0;
    case (step)
      STEP_FWD: delta = COUNT_WIDTH'(1);
      STEP_REV: delta = '1;
      default:  delta = '0;
    endcase
    moved      = (step == STEP_FWD) || (step == STEP_REV);
    count_next = COUNT + delta;
  end

  // An illegal step coinciding with CLEAR still sets ERROR, so it is not lost.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT         <= '0;
      COUNT_LATCHED <= '0;
      DIR           <= 1'b0;
      ERROR         <= 1'b0;
    end else begin
      COUNT <= CLEAR ? delta : count_next;
      if (SNAPSHOT) COUNT_LATCHED <= count_next;
      if (moved)    DIR           <= (step == STEP_FWD);
      ERROR <= (ERROR & ~CLEAR) | (step == STEP_ILLEGAL);
    end
  end

`ifdef QUAD_VELOCITY_EN
  logic [PERIOD_WIDTH-1:0] cycles;

  // The interval counter starts saturated: no step has been seen yet.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cycles         <= '1;
      PERIOD         <= '1;
      PERIOD_LATCHED <= '1;
    end else begin
      if (moved) begin
        PERIOD <= cycles;
        cycles <= PERIOD_WIDTH'(1);
      end else if (cycles != '1) begin
        cycles <= cycles + 1'b1;
      end
      if (SNAPSHOT) PERIOD_LATCHED <= moved ? cycles : PERIOD;
    end
  end
`endif

endmodule

// File: doc/quadrature_counter.md
Name: quadrature_counter

Overview:
- Per-wheel quadrature decoder and position counter.
- Sits between the raw WHEEL_SENSOR pin pair and the SPI register readout. System instantiates one per wheel and indexes the instances by sensor pair.
- Synchronises and glitch-filters the A/B pins, decodes 4x quadrature into a signed position count, and keeps a snapshot copy so SPI reads all wheels coherently.

Parameters:
- FILTER_LEN, 3: consecutive stable samples required before a pin change is accepted; 0 bypasses the filter.
- COUNT_WIDTH, 32: width of position count and snapshot, two's complement.

Ports:
- CLK  in  1  system clock (16 MHz domain).
- RESET_N  in  1  asynchronous, active-low reset.
- SENSOR  in  2  raw quadrature pins; bit0 = A, bit1 = B; asynchronous to CLK.
- SNAPSHOT  in  1  one-cycle pulse from the SPI command decoder; latch count.
- CLEAR  in  1  one-cycle pulse; zero the live count.
- COUNT  out  COUNT_WIDTH  live signed position.
- COUNT_LATCHED  out  COUNT_WIDTH  value captured at the last SNAPSHOT.
- DIR  out  1  direction of last accepted step; 1 = forward.
- ERROR  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (async assert, sync release via CLK): COUNT = 0, COUNT_LATCHED = 0, DIR = 0, ERROR = 0.
- Reset also clears the synchroniser and filter registers. The filtered state reloads from the pins FILTER_LEN+2 cycles after release, with no step counted for this reload.
- Synchroniser: two flops per pin (s1, s2).
- Filter, per pin: counter of consecutive cycles where s2 != filt.
  - Counter resets to 0 whenever s2 == filt.
  - When the counter reaches FILTER_LEN, filt <= s2 and the counter clears.
  - A glitch shorter than FILTER_LEN cycles never reaches filt.
- Decoder: compares the previous filtered AB (prev) with the current filtered AB (cur) each cycle. The filtered sequence is 00 -> 01 -> 11 -> 10 -> 00.
  - Forward steps (delta = +1): 00->01, 01->11, 11->10, 10->00.
  - Reverse steps (delta = -1): the inverse transitions.
  - No change: delta = 0.
  - Both bits changed (00<->11, 01<->10): delta = 0 and ERROR <= 1. ERROR clears only on reset or CLEAR.
- DIR updates only on a nonzero delta.
- Latency: a clean pin edge held stable changes COUNT FILTER_LEN+3 cycles after the first CLK edge that samples it.
- Arithmetic: next = COUNT + delta, modulo 2^COUNT_WIDTH.
  - 0x7FFFFFFF + 1 = 0x80000000.
  - 0 - 1 = 0xFFFFFFFF.
  - No saturation.
- SNAPSHOT: COUNT_LATCHED <= next, so a same-cycle step is included.
- CLEAR: COUNT <= delta, so a same-cycle step is kept, not lost. ERROR <= 0.
- SNAPSHOT and CLEAR in the same cycle: COUNT_LATCHED gets the pre-clear next; COUNT restarts from delta.
- Pulses are level-sampled. Held high for N cycles, SNAPSHOT and CLEAR act on each of the N cycles.

Optional Feature:
- Macro QUAD_VELOCITY_EN.
- Defined:
  - Adds output PERIOD (16 bits), the CLK cycles between the two most recent accepted steps.
  - A free-running 16-bit cycle counter saturates at 0xFFFF (wheel stalled) and restarts at 1 on each step, when its value is copied to PERIOD.
  - PERIOD resets to 0xFFFF.
  - SNAPSHOT also latches PERIOD_LATCHED.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: quadrature step encodings (forward/reverse/none/illegal), the COUNT_WIDTH default, and the PERIOD width.
- Sub-module quad_input_filter: one instance per pin containing synchroniser plus stability counter, parameterised by FILTER_LEN.
- Decoder and counter stay in quadrature_counter.

Test Plan:
- 25 forward cycles on SENSOR (00,01,11,10), 1 us per state, then SNAPSHOT -> COUNT = COUNT_LATCHED = 0x00000064, DIR = 1, ERROR = 0.
- 12 reverse cycles (00,10,11,01) from reset -> COUNT = 0xFFFFFFD0, DIR = 0.
- Glitch on A lasting FILTER_LEN-1 cycles (2 cycles at default) -> COUNT unchanged.
  - Same pulse held FILTER_LEN cycles -> COUNT = 1 exactly FILTER_LEN+3 cycles after the edge.
- Step 00 -> 11 directly -> COUNT unchanged, ERROR = 1 and stays 1.
  - Next CLEAR -> ERROR = 0, COUNT = 0.
- Force COUNT to 0x7FFFFFFF via 2^31-1 steps (or hierarchical preload), then one forward step -> 0x80000000.
  - From reset, one reverse step -> 0xFFFFFFFF.
- After 5 forward steps, SNAPSHOT and CLEAR asserted in the cycle of a sixth step -> COUNT_LATCHED = 6, COUNT = 1.
  - RESET_N pulsed mid-sequence -> all outputs 0 immediately, without waiting for a CLK edge.
